flag_grid_ctrl: RTL
===================

FLAG_GRID_CTRL -- requirements
Module: flag_grid_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MAX_DIM, 16: largest board side in cells.
- IDX_W, 5: width of the 1-based cell index.
- CNT_W, 9: width of the flag counter.
- DIM_E / DIM_M / DIM_H, 8 / 10 / 16: board side for levels 1 / 2 / 3.
- MAXF_E / MAXF_M / MAXF_H, 10 / 20 / 40: flag limit for each level.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst_n, in, 1: reset, synchronous, active-low.
- level, in, 2: game level; 3 is hard, 2 is medium, any other value is easy.
- clear_req, in, 1: one-cycle request to wipe all flags.
- mark_flag, in, 1: one-cycle request to toggle a flag.
- flag_ind_x / flag_ind_y, in, IDX_W each: 1-based cell coordinates for mark_flag.
- cell_revealed, in, 1: the addressed cell is already uncovered; valid in the same cycle as mark_flag.
- rd_x / rd_y, in, IDX_W each: 1-based read coordinates.
- flag_arr, out, MAX_DIM x MAX_DIM packed, indexed [x-1][y-1]: the flag map.
- rd_flag, out, 1: flag state at rd_x / rd_y, registered.
- flag_cnt, out, CNT_W: number of flags currently placed.
- flags_left, out, CNT_W: active limit minus flag_cnt.
- busy, out, 1: a clear sweep is in progress.
- mark_done, out, 1: pulse, the mark was accepted.
- mark_rej, out, 1: pulse, the mark was rejected.

Function
REQ-003 The active dimension (dim) and flag limit (maxf) SHALL be selected from lvl_q, the registered level, using the parameter set for that level.
REQ-004 The FSM SHALL have two states, IDLE and CLEAR.
REQ-005 In IDLE, the block SHALL enter CLEAR when clear_req=1, or when level differs from lvl_q; on entry it loads lvl_q from level and sets flag_cnt to 0.
REQ-006 In CLEAR, the block SHALL zero one full row of flag_arr per cycle, rows 0 to MAX_DIM-1, and return to IDLE after row MAX_DIM-1; the sweep lasts exactly MAX_DIM cycles.
REQ-007 busy SHALL be 1 in every cycle the FSM is in CLEAR and 0 in IDLE.
REQ-008 In CLEAR, further clear_req pulses and level changes SHALL be ignored. A level change still pending at the end of the sweep triggers a new sweep from IDLE.
REQ-009 A mark_flag in IDLE SHALL be accepted only when all of the following hold:
- 1 <= flag_ind_x <= dim and 1 <= flag_ind_y <= dim;
- cell_revealed=0;
- the cell is already flagged, or flag_cnt < maxf.
REQ-010 An accepted mark SHALL toggle flag_arr[x-1][y-1] and change flag_cnt by +1 (flag placed) or -1 (flag removed). The new values are visible on the cycle after mark_flag, together with a one-cycle mark_done pulse.
REQ-011 A rejected mark SHALL leave flag_arr and flag_cnt unchanged and produce a one-cycle mark_rej pulse on the cycle after mark_flag.
REQ-012 A mark_flag that arrives while in CLEAR, or in the same cycle that a clear is triggered, SHALL be rejected; clear has priority.
REQ-013 mark_done and mark_rej SHALL never be 1 in the same cycle.
REQ-014 Without mark_flag, both mark_done and mark_rej SHALL stay 0.
REQ-015 flags_left SHALL be computed combinationally as maxf - flag_cnt and SHALL never underflow, since flag_cnt <= maxf always holds.
REQ-016 rd_flag SHALL equal flag_arr[rd_x-1][rd_y-1] one cycle after rd_x / rd_y are presented; rd_flag SHALL be 0 when either coordinate is 0 or greater than MAX_DIM.
REQ-017 Cells with an index above dim SHALL stay 0 at all times.
REQ-018 Index arithmetic SHALL be IDX_W wide with no wrap-around: a coordinate of 0 is rejected, never mapped to MAX_DIM-1.

Reset
REQ-019 When rst_n=0 at a clock edge, the block SHALL on that edge:
- set the FSM to IDLE;
- clear all of flag_arr to 0 in one cycle;
- set flag_cnt, rd_flag, busy, mark_done and mark_rej to 0;
- load lvl_q from level.
REQ-020 A reset during CLEAR SHALL abort the sweep; no automatic clear follows reset release.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Easy toggle: level=1, mark (3,4) -> next cycle flag_arr[2][3]=1, flag_cnt=1, flags_left=9, mark_done=1. Mark (3,4) again -> bit=0, flag_cnt=0.
- Bounds: level=2, mark (11,1) and then (0,5) -> mark_rej=1 for each, flag_cnt unchanged, flag_arr unchanged.
- Limit: level=1, place 10 distinct flags, then mark an 11th new cell -> mark_rej=1, flag_cnt=10. Remove one of the placed flags -> mark_done=1, flag_cnt=9.
- Revealed cell: mark (2,2) with cell_revealed=1 -> mark_rej=1, bit remains 0.
- Level change: flags placed at level 3, then level driven to 1 -> busy=1 for exactly 16 cycles, flag_cnt=0 from the first busy cycle, all bits 0 at the end. A mark issued while busy -> mark_rej=1.
- Reset mid-sweep: rst_n=0 on sweep cycle 5 -> next cycle busy=0, flag_arr all 0, flag_cnt=0. After rst_n returns to 1, no new sweep starts with level held constant.

Source files
------------

// File: rtl/flag_grid_ctrl.sv
// flag_grid_ctrl
// Flag map controller for a square minesweeper-style board.
// Keeps a MAX_DIM x MAX_DIM flag bitmap and a flag counter, toggles flags on
// request, and wipes the map one row per cycle when cleared or when the game
// level changes.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   level                      game level (3 hard, 2 medium, else easy)
//   clear_req                  one-cycle request to wipe all flags
//   mark_flag                  one-cycle request to toggle the flag at
//                              flag_ind_x / flag_ind_y (1-based)
//   cell_revealed              addressed cell is uncovered (with mark_flag)
//   rd_x, rd_y                 1-based read coordinates
//   flag_arr                   flag map, indexed [x-1][y-1]
//   rd_flag                    registered flag at rd_x / rd_y
//   flag_cnt, flags_left       placed flags, remaining flags for this level
//   busy                       clear sweep in progress
//   mark_done, mark_rej        one-cycle accept / reject pulses for a mark
//
// Handshake: there is no back-pressure. Every mark_flag pulse is answered on
// the following cycle by exactly one of mark_done or mark_rej; a clear or a
// level change is always taken in IDLE and silently dropped while busy.
module flag_grid_ctrl #(
    parameter int MAX_DIM = 16,
    parameter int IDX_W   = 5,
    parameter int CNT_W   = 9,
    parameter int DIM_E   = 8,
    parameter int DIM_M   = 10,
    parameter int DIM_H   = 16,
    parameter int MAXF_E  = 10,
    parameter int MAXF_M  = 20,
    parameter int MAXF_H  = 40
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      level,
    input  logic                            clear_req,
    input  logic                            mark_flag,
    input  logic [IDX_W-1:0]                flag_ind_x,
    input  logic [IDX_W-1:0]                flag_ind_y,
    input  logic                            cell_revealed,
    input  logic [IDX_W-1:0]                rd_x,
    input  logic [IDX_W-1:0]                rd_y,
    output logic [MAX_DIM-1:0][MAX_DIM-1:0] flag_arr,
    output logic                            rd_flag,
    output logic [CNT_W-1:0]                flag_cnt,
    output logic [CNT_W-1:0]                flags_left,
    output logic                            busy,
    output logic                            mark_done,
    output logic                            mark_rej
);

    localparam int AW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        lvl_q;
    logic [AW-1:0]     row;
    logic [IDX_W-1:0]  dim;
    logic [CNT_W-1:0]  maxf;
    logic              clr_trig;
    logic              row_last;

    // Board geometry follows the registered level so it cannot change
    // underneath a sweep or a mark.
    always_comb begin
        dim  = IDX_W'(DIM_E);
        maxf = CNT_W'(MAXF_E);
        case (lvl_q)
            2'd3: begin
                dim  = IDX_W'(DIM_H);
                maxf = CNT_W'(MAXF_H);
            end
            2'd2: begin
                dim  = IDX_W'(DIM_M);
                maxf = CNT_W'(MAXF_M);
            end
            default: begin
                dim  = IDX_W'(DIM_E);
                maxf = CNT_W'(MAXF_E);
            end
        endcase
    end

    assign flags_left = maxf - flag_cnt;
    assign row_last   = (row == AW'(MAX_DIM - 1));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state and state-derived outputs
    always_comb begin
        state_nxt = state;
        clr_trig  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req || (level != lvl_q)) begin
                    clr_trig  = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (row_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mark decode. Coordinates are range-checked at full IDX_W width before
    // the 0-based index is used, so a 0 coordinate can never alias a cell.
    logic [AW-1:0] mxi;
    logic [AW-1:0] myi;
    logic          mark_in_range;
    logic          cur_flag;
    logic          mark_ok;

    assign mxi           = AW'(flag_ind_x - IDX_W'(1));
    assign myi           = AW'(flag_ind_y - IDX_W'(1));
    assign mark_in_range = (flag_ind_x != '0) && (flag_ind_x <= dim) &&
                           (flag_ind_y != '0) && (flag_ind_y <= dim);
    assign cur_flag      = flag_arr[mxi][myi];
    // A clear triggered in this same cycle takes priority over the mark.
    assign mark_ok       = (state == IDLE) && !clr_trig && mark_in_range &&
                           !cell_revealed && (cur_flag || (flag_cnt < maxf));

    // Read port decode
    logic [AW-1:0] rxi;
    logic [AW-1:0] ryi;
    logic          rd_ok;

    assign rxi   = AW'(rd_x - IDX_W'(1));
    assign ryi   = AW'(rd_y - IDX_W'(1));
    assign rd_ok = (rd_x != '0) && (rd_x <= IDX_W'(MAX_DIM)) &&
                   (rd_y != '0) && (rd_y <= IDX_W'(MAX_DIM));

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_arr  <= '0;
            flag_cnt  <= '0;
            rd_flag   <= 1'b0;
            mark_done <= 1'b0;
            mark_rej  <= 1'b0;
            lvl_q     <= level;
            row       <= '0;
        end else begin
            mark_done <= mark_flag && mark_ok;
            mark_rej  <= mark_flag && !mark_ok;
            rd_flag   <= rd_ok ? flag_arr[rxi][ryi] : 1'b0;
            if (clr_trig) begin
                lvl_q    <= level;
                flag_cnt <= '0;
                row      <= '0;
            end else if (state == CLEAR) begin
                flag_arr[row] <= '0;
                row           <= row + AW'(1);
            end else if (mark_flag && mark_ok) begin
                flag_arr[mxi][myi] <= ~cur_flag;
                flag_cnt           <= cur_flag ? (flag_cnt - CNT_W'(1))
                                               : (flag_cnt + CNT_W'(1));
            end
        end
    end

endmodule
